// File: rtl/div_arbiter.sv
// Round-robin arbiter that shares one iterative start/done divider among LANES
// requesters, with local divide-by-zero handling and a watchdog on the divider.
module div_arbiter #(
    parameter int N       = 8,
    parameter int LANES   = 4,
    parameter int TIMEOUT = 2 * N + 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [LANES-1:0]   req_valid,
    output logic [LANES-1:0]   req_ready,
    input  logic [LANES*N-1:0] req_dividend,
    input  logic [LANES*N-1:0] req_divisor,
    output logic [LANES-1:0]   rsp_valid,
    input  logic [LANES-1:0]   rsp_ready,
    output logic [N-1:0]       rsp_result,
    output logic [1:0]         rsp_status,
    output logic               busy,
    output logic               div_start,
    output logic [N-1:0]       div_dividend,
    output logic [N-1:0]       div_divisor,
    input  logic [N-1:0]       div_result,
    input  logic               div_done
);

    localparam int LW = $clog2(LANES);
    localparam int WW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_OK = 2'b00;
    localparam logic [1:0] ST_DZ = 2'b01;
    localparam logic [1:0] ST_TO = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t        state_r, state_s;
    logic [LW-1:0] lane_r, lane_s;
    logic [LW-1:0] rr_ptr_r, rr_ptr_s;
    logic [N-1:0]  dividend_r, dividend_s;
    logic [N-1:0]  divisor_r, divisor_s;
    logic [N-1:0]  result_r, result_s;
    logic [1:0]    status_r, status_s;
    logic [WW-1:0] wdog_r, wdog_s;

    logic          grant_found_s;
    logic [LW-1:0] grant_lane_s;
    logic [LW-1:0] cand_s;
    logic [N-1:0]  grant_dividend_s;
    logic [N-1:0]  grant_divisor_s;

    // Lane index arithmetic modulo LANES (LANES need not be a power of two).
    function automatic logic [LW-1:0] lane_add(input logic [LW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= LANES) begin
            sum = sum - LANES;
        end else begin
            sum = sum;
        end
        return LW'(sum);
    endfunction

    // Round-robin search starting at the pointer, wrapping past the last lane.
    always_comb begin
        grant_found_s = 1'b0;
        grant_lane_s  = {LW{1'b0}};
        cand_s        = {LW{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            cand_s = lane_add(rr_ptr_r, i);
            if (!grant_found_s && req_valid[cand_s]) begin
                grant_found_s = 1'b1;
                grant_lane_s  = cand_s;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
        grant_dividend_s = req_dividend[grant_lane_s*N +: N];
        grant_divisor_s  = req_divisor[grant_lane_s*N +: N];
    end

    // Grant is combinational but gated by reset so nothing is accepted while held in reset.
    always_comb begin
        req_ready = {LANES{1'b0}};
        if (reset && (state_r == S_IDLE) && grant_found_s) begin
            req_ready[grant_lane_s] = 1'b1;
        end else begin
            req_ready = {LANES{1'b0}};
        end
    end

    // Response flag decoded from registered state and lane id.
    always_comb begin
        rsp_valid = {LANES{1'b0}};
        if (state_r == S_RESP) begin
            rsp_valid[lane_r] = 1'b1;
        end else begin
            rsp_valid = {LANES{1'b0}};
        end
    end

    assign busy         = (state_r != S_IDLE);
    assign div_start    = (state_r == S_ISSUE);
    assign div_dividend = dividend_r;
    assign div_divisor  = divisor_r;
    assign rsp_result   = result_r;
    assign rsp_status   = status_r;

    // Next-state and datapath update for the job FSM.
    always_comb begin
        state_s    = state_r;
        lane_s     = lane_r;
        rr_ptr_s   = rr_ptr_r;
        dividend_s = dividend_r;
        divisor_s  = divisor_r;
        result_s   = result_r;
        status_s   = status_r;
        wdog_s     = wdog_r;
        case (state_r)
            S_IDLE: begin
                if (grant_found_s) begin
                    lane_s     = grant_lane_s;
                    dividend_s = grant_dividend_s;
                    divisor_s  = grant_divisor_s;
                    if (grant_divisor_s == {N{1'b0}}) begin
                        result_s = {N{1'b1}};
                        status_s = ST_DZ;
                        state_s  = S_RESP;
                    end else begin
                        state_s  = S_ISSUE;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ISSUE: begin
                wdog_s  = {WW{1'b0}};
                state_s = S_WAIT;
            end
            S_WAIT: begin
                if (div_done) begin
                    result_s = div_result;
                    status_s = ST_OK;
                    state_s  = S_RESP;
                end else if (wdog_r == WW'(TIMEOUT - 1)) begin
                    result_s = {N{1'b1}};
                    status_s = ST_TO;
                    state_s  = S_RESP;
                end else begin
                    wdog_s   = wdog_r + WW'(1);
                end
            end
            S_RESP: begin
                // Only the granted lane's rsp_ready completes the handshake.
                if (rsp_ready[lane_r]) begin
                    rr_ptr_s = lane_add(lane_r, 1);
                    state_s  = S_IDLE;
                end else begin
                    state_s  = S_RESP;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= S_IDLE;
            lane_r     <= {LW{1'b0}};
            rr_ptr_r   <= {LW{1'b0}};
            dividend_r <= {N{1'b0}};
            divisor_r  <= {N{1'b0}};
            result_r   <= {N{1'b0}};
            status_r   <= 2'b00;
            wdog_r     <= {WW{1'b0}};
        end else begin
            state_r    <= state_s;
            lane_r     <= lane_s;
            rr_ptr_r   <= rr_ptr_s;
            dividend_r <= dividend_s;
            divisor_r  <= divisor_s;
            result_r   <= result_s;
            status_r   <= status_s;
            wdog_r     <= wdog_s;
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// Directed self-checking bench for div_arbiter with a behavioural divider whose
// latency is programmable and which can be told never to finish.
module tb_div_arbiter;

    localparam int N = 8;
    localparam int L = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [L-1:0] req_valid;
    logic [L-1:0] req_ready;
    logic [L*N-1:0] req_dividend;
    logic [L*N-1:0] req_divisor;
    logic [L-1:0] rsp_valid;
    logic [L-1:0] rsp_ready;
    logic [N-1:0] rsp_result;
    logic [1:0]   rsp_status;
    logic         busy;
    logic         div_start;
    logic [N-1:0] div_dividend;
    logic [N-1:0] div_divisor;
    logic [N-1:0] div_result;
    logic         div_done;

    int   n_cmp = 0;
    int   n_err = 0;
    int   dly = 2;
    bit   never = 1'b0;
    logic spur_done = 1'b0;

    logic         m_busy;
    int           m_cnt;
    logic         m_done;
    logic [N-1:0] m_q;

    div_arbiter #(.N(N), .LANES(L), .TIMEOUT(2 * N + 8)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_status   (rsp_status),
        .busy         (busy),
        .div_start    (div_start),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_result   (div_result),
        .div_done     (div_done)
    );

    always #5 clk = ~clk;

    // Divider stand-in: done rises dly cycles after start and holds until the next start.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_q    <= 8'h00;
        end else if (div_start) begin
            m_busy <= 1'b1;
            m_cnt  <= dly;
            m_done <= 1'b0;
            m_q    <= (div_divisor != 8'h00) ? div_dividend / div_divisor : 8'hff;
        end else if (m_busy && !never) begin
            if (m_cnt <= 1) begin
                m_done <= 1'b1;
                m_busy <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    assign div_done   = m_done | spur_done;
    assign div_result = m_q;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int lane, input logic [N-1:0] a, input logic [N-1:0] b);
        req_dividend[lane*N +: N] = a;
        req_divisor[lane*N +: N]  = b;
        req_valid[lane]           = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_result"}, 32'(rsp_result), 32'd0);
        chk({tag, "_rsp_status"}, 32'(rsp_status), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_div_start"}, 32'(div_start), 32'd0);
        chk({tag, "_div_dividend"}, 32'(div_dividend), 32'd0);
        chk({tag, "_div_divisor"}, 32'(div_divisor), 32'd0);
    endtask

    // Full job: grant, issue, response with expected latency (cycles from grant), handshake.
    task automatic run_job(input int lane, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [N-1:0] res, input logic [1:0] st,
                           input int lat, input bit drop);
        int n;
        #1;
        n = 0;
        while (req_ready == 4'b0000 && n < 50) begin
            tick();
            n++;
        end
        chk("grant", 32'(req_ready), 32'd1 << lane);
        tick();
        if (drop) req_valid[lane] = 1'b0;
        chk("busy_up", 32'(busy), 32'd1);
        chk("start", 32'(div_start), (st == 2'b01) ? 32'd0 : 32'd1);
        if (st != 2'b01) begin
            chk("div_dividend", 32'(div_dividend), 32'(a));
            chk("div_divisor", 32'(div_divisor), 32'(b));
        end
        n = 1;
        while (rsp_valid == 4'b0000 && n < 100) begin
            tick();
            n++;
        end
        chk("latency", 32'(n), 32'(lat));
        chk("rsp_valid", 32'(rsp_valid), 32'd1 << lane);
        chk("rsp_result", 32'(rsp_result), 32'(res));
        chk("rsp_status", 32'(rsp_status), 32'(st));
        chk("start_in_resp", 32'(div_start), 32'd0);
        rsp_ready = rsp_valid;
        tick();
        rsp_ready = 4'b0000;
        chk("busy_down", 32'(busy), 32'd0);
        chk("rsp_clear", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int n;
        reset        = 1'b0;
        req_valid    = 4'b0000;
        rsp_ready    = 4'b0000;
        req_dividend = 32'd0;
        req_divisor  = 32'd0;
        #1;
        chk_reset_outputs("por");
        tick();
        tick();
        reset = 1'b1;

        // Lane 1: 200/7 with an 8-cycle divider.
        dly = 8;
        set_req(1, 8'd200, 8'd7);
        run_job(1, 8'd200, 8'd7, 8'd28, 2'b00, 11, 1'b1);

        // Lane 2: divide by zero, answered locally.
        set_req(2, 8'd55, 8'd0);
        run_job(2, 8'd55, 8'd0, 8'hff, 2'b01, 1, 1'b1);

        // Reset while idle brings the pointer back to lane 0.
        reset = 1'b0;
        #1;
        chk("idle_reset_busy", 32'(busy), 32'd0);
        tick();
        reset = 1'b1;

        // All four lanes request; lanes keep requesting after service.
        dly = 2;
        for (int i = 0; i < L; i++) set_req(i, 8'd60, 8'(i + 1));
        run_job(0, 8'd60, 8'd1, 8'd60, 2'b00, 5, 1'b0);
        run_job(1, 8'd60, 8'd2, 8'd30, 2'b00, 5, 1'b0);
        run_job(2, 8'd60, 8'd3, 8'd20, 2'b00, 5, 1'b0);
        run_job(3, 8'd60, 8'd4, 8'd15, 2'b00, 5, 1'b0);
        req_valid[1] = 1'b0;
        req_valid[2] = 1'b0;
        run_job(0, 8'd60, 8'd1, 8'd60, 2'b00, 5, 1'b1);
        run_job(3, 8'd60, 8'd4, 8'd15, 2'b00, 5, 1'b1);

        // Backpressure in RESP; other lanes' rsp_ready must not complete it.
        set_req(0, 8'd9, 8'd3);
        set_req(2, 8'd8, 8'd0);
        #1;
        chk("bp_grant", 32'(req_ready), 32'd1);
        tick();
        req_valid[0] = 1'b0;
        n = 1;
        while (rsp_valid == 4'b0000 && n < 100) begin
            tick();
            n++;
        end
        chk("bp_latency", 32'(n), 32'd5);
        rsp_ready = 4'b1110;
        for (int c = 0; c < 5; c++) begin
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_result", 32'(rsp_result), 32'd3);
            chk("bp_rsp_status", 32'(rsp_status), 32'd0);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_div_start", 32'(div_start), 32'd0);
            tick();
        end
        rsp_ready = 4'b0001;
        tick();
        rsp_ready = 4'b0000;
        chk("bp_release_busy", 32'(busy), 32'd0);
        chk("bp_next_grant", 32'(req_ready), 32'd4);
        tick();
        req_valid[2] = 1'b0;
        chk("bp_dz_valid", 32'(rsp_valid), 32'd4);
        chk("bp_dz_result", 32'(rsp_result), 32'hff);
        chk("bp_dz_status", 32'(rsp_status), 32'd1);
        rsp_ready = 4'b0100;
        tick();
        rsp_ready = 4'b0000;
        chk("bp_dz_done", 32'(busy), 32'd0);

        // Divider never finishes: watchdog fires, later done is ignored.
        never = 1'b1;
        set_req(1, 8'd1, 8'd1);
        run_job(1, 8'd1, 8'd1, 8'hff, 2'b10, 26, 1'b1);
        spur_done = 1'b1;
        tick();
        tick();
        chk("spur_busy", 32'(busy), 32'd0);
        chk("spur_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("spur_status", 32'(rsp_status), 32'd2);
        chk("spur_result", 32'(rsp_result), 32'hff);
        spur_done = 1'b0;
        never = 1'b0;

        // Reset during WAIT drops the job; pointer restarts at lane 0.
        dly = 8;
        set_req(3, 8'd50, 8'd5);
        #1;
        chk("wr_grant", 32'(req_ready), 32'd8);
        tick();
        tick();
        tick();
        chk("wr_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk_reset_outputs("wait_reset");
        tick();
        reset = 1'b1;
        set_req(1, 8'd100, 8'd10);
        run_job(1, 8'd100, 8'd10, 8'd10, 2'b00, 11, 1'b1);
        run_job(3, 8'd50, 8'd5, 8'd10, 2'b00, 11, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no completion expected $finish");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/div_arbiter.md
# div_arbiter

Shares one iterative `divider` (start/done handshake, N-bit dividend/divisor/result) among LANES requesters, such as per-thread ALU lanes in a core. It grants requests round-robin, latches operands, and pulses the divider's start. It then waits for done, or for a watchdog timeout, and returns the quotient to the granted lane over a valid/ready response channel. Divide-by-zero is handled locally without occupying the divider.

## Interface
- N, 8: operand/result width.
- LANES, 4: number of requesters (≥2).
- TIMEOUT, 2*N+8: maximum WAIT cycles before abort.
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
- req_valid  in  LANES  per-lane request; held with operands stable until req_ready.
- req_ready  out  LANES  one-hot, combinational; high only for the lane accepted this cycle.
- req_dividend  in  LANES*N  lane i at [i*N +: N].
- req_divisor  in  LANES*N  lane i at [i*N +: N].
- rsp_valid  out  LANES  one-hot; response pending for that lane.
- rsp_ready  in  LANES  per-lane response accept.
- rsp_result  out  N  quotient for the lane flagged in rsp_valid.
- rsp_status  out  2  00 ok, 01 divide-by-zero, 10 timeout.
- busy  out  1  state ≠ IDLE.
- div_start  out  1  one-cycle start pulse to divider.
- div_dividend, div_divisor  out  N each  latched operands to divider.
- div_result  in  N  divider quotient.
- div_done  in  1  divider completion.

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Registers: state, lane id, rr pointer (log2 LANES), operand latches, result, status, watchdog counter.
- IDLE:
  - Grant the first lane with req_valid set, searching from rr pointer upward with wrap.
  - Assert req_ready for that lane and latch its operands and the lane id.
  - divisor==0 → result=all-ones, status=01, go RESP (divider untouched).
  - Otherwise go ISSUE.
- ISSUE: div_start=1 for exactly this cycle. Clear watchdog. Go WAIT.
- WAIT:
  - div_done=1 → capture div_result, status=00, go RESP.
  - Otherwise increment watchdog. At watchdog==TIMEOUT-1 with no done → result=all-ones, status=10, go RESP.
  - Divider contract: done is low on the first WAIT cycle; the divider clears done at the edge that samples start.
- RESP:
  - rsp_valid[lane]=1, with rsp_result/rsp_status stable.
  - On rsp_ready[lane]: rr pointer = (lane+1) mod LANES, go IDLE.
  - rsp_ready on other lanes is ignored.
- div_dividend/div_divisor hold the latched values from ISSUE through WAIT. div_start is 0 in all other states.
- Requests from non-granted lanes wait; no queueing beyond the single in-flight job.
- A late div_done after timeout (in RESP/IDLE) is ignored.

## Timing
- Reset values: state IDLE, rr pointer 0, all outputs 0 (req_ready, rsp_valid, rsp_result, rsp_status, busy, div_start, div_dividend, div_divisor).
- Reset mid-operation: in-flight job is dropped with no response. The requester must re-issue. The divider is reset by the same system reset.
- Normal job, grant at cycle t:
  - t+1: div_start.
  - t+2: first WAIT cycle.
  - Done seen at t+2+k → rsp_valid from t+3+k.
- Divide-by-zero: rsp_valid at t+1.
- Timeout: rsp_valid TIMEOUT cycles after the first WAIT cycle.
- After the response handshake: one IDLE cycle before the next grant. Maximum throughput is one job per (k+4) cycles.
- rsp_ready asserted in the first RESP cycle: response completes that cycle.
- busy rises the cycle after grant and falls the cycle after the response handshake.

## Test plan
- Lane 1 requests 200/7, divider model done after 8 cycles → req_ready[1] at grant cycle, div_start one cycle, rsp_valid[1] with result 28, status 00.
- Lane 2 requests 55/0 → rsp_valid[2] at grant+1, result 0xFF, status 01, div_start never asserted.
- All 4 lanes request simultaneously from reset (ptr 0), each re-asserting after service → grants 0,1,2,3. Then lanes 0 and 3 re-request → order 0, 3.
- Hold rsp_ready low 5 cycles in RESP → rsp_valid/result/status stable, no req_ready, div_start 0. Release → IDLE next cycle.
- Divider model never asserts done (N=8, TIMEOUT=24) → response exactly 24 cycles after first WAIT cycle, result 0xFF, status 10. A later spurious done is ignored.
- Drive reset low during WAIT → all outputs 0 immediately. After release, a new 100/10 request returns 10, status 00, grant order from lane 0.
